// File: rtl/display_pkg.sv
// Shared encodings for the display-mode controller: mode numbers, UART command bytes
// and the millisecond divider helper.
package display_pkg;

    localparam int MODE_TEMP = 0;
    localparam int MODE_HUMI = 1;
    localparam int MODE_BOTH = 2;

    localparam logic [7:0] CH_T_UP    = 8'h54;
    localparam logic [7:0] CH_T_LO    = 8'h74;
    localparam logic [7:0] CH_H_UP    = 8'h48;
    localparam logic [7:0] CH_H_LO    = 8'h68;
    localparam logic [7:0] CH_A_UP    = 8'h41;
    localparam logic [7:0] CH_A_LO    = 8'h61;
    localparam logic [7:0] CH_R_UP    = 8'h52;
    localparam logic [7:0] CH_R_LO    = 8'h72;
    localparam logic [7:0] CH_DIGIT_0 = 8'h30;
    localparam logic [7:0] CH_DIGIT_9 = 8'h39;

    typedef struct packed {
        logic       sel_valid;
        logic [3:0] sel_mode;
        logic       toggle_auto;
    } uart_cmd_t;

    function automatic int MS_DIV(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Range checking against NUM_MODES is left to the caller.
    function automatic uart_cmd_t decode_uart(input logic [7:0] b);
        uart_cmd_t cmd;
        cmd = '0;
        case (b)
            CH_T_UP, CH_T_LO: begin
                cmd.sel_valid = 1'b1;
                cmd.sel_mode  = 4'(MODE_TEMP);
            end
            CH_H_UP, CH_H_LO: begin
                cmd.sel_valid = 1'b1;
                cmd.sel_mode  = 4'(MODE_HUMI);
            end
            CH_A_UP, CH_A_LO: begin
                cmd.sel_valid = 1'b1;
                cmd.sel_mode  = 4'(MODE_BOTH);
            end
            CH_R_UP, CH_R_LO: begin
                cmd.toggle_auto = 1'b1;
            end
            default: begin
                if (b >= CH_DIGIT_0 && b <= CH_DIGIT_9) begin
                    cmd.sel_valid = 1'b1;
                    cmd.sel_mode  = 4'(b - CH_DIGIT_0);
                end
            end
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running one-cycle pulse every CLK_HZ/1000 clocks; a divider of 1 ticks every cycle.
module ms_tick_gen
    import display_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV   = MS_DIV(CLK_HZ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/display_mode_ctrl.sv
// Display-mode selector with button/UART control, auto-rotate, stretched data-ready LED
// and a stale-sensor flag, all timed from a shared millisecond tick.
module display_mode_ctrl
    import display_pkg::*;
#(
    parameter int NUM_MODES  = 3,
    parameter int MODE_W     = 2,
    parameter int INIT_MODE  = 2,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DWELL_MS   = 2000,
    parameter int STRETCH_MS = 100,
    parameter int STALE_MS   = 12000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_auto,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              data_ready,
    output logic [MODE_W-1:0] display_mode,
    output logic              auto_rotate,
    output logic              mode_changed,
    output logic              ready_led,
    output logic              stale
);

    localparam int DWELL_W   = $clog2(DWELL_MS + 1);
    localparam int STRETCH_W = $clog2(STRETCH_MS + 1);
    localparam int STALE_W   = $clog2(STALE_MS + 1);

    logic                 tick;
    logic                 btn_mode_q;
    logic                 btn_auto_q;
    uart_cmd_t            cmd;
    logic                 mode_edge;
    logic                 auto_edge;
    logic                 uart_sel;
    logic                 manual_evt;
    logic                 dwell_expire;
    logic                 auto_toggle;
    logic [MODE_W-1:0]    mode_step;
    logic [MODE_W-1:0]    mode_next;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [STRETCH_W-1:0] stretch_cnt;
    logic [STRETCH_W-1:0] stretch_next;
    logic [STALE_W-1:0]   silence_cnt;
    logic [STALE_W-1:0]   silence_next;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_mode_q <= 1'b0;
            btn_auto_q <= 1'b0;
        end else begin
            btn_mode_q <= btn_mode;
            btn_auto_q <= btn_auto;
        end
    end

    // Selects beyond the configured mode count are treated as unknown bytes.
    always_comb begin
        cmd          = rx_done ? decode_uart(rx_data) : '0;
        mode_edge    = btn_mode & ~btn_mode_q;
        auto_edge    = btn_auto & ~btn_auto_q;
        uart_sel     = cmd.sel_valid && (int'(cmd.sel_mode) < NUM_MODES);
        manual_evt   = uart_sel | mode_edge;
        auto_toggle  = auto_edge | cmd.toggle_auto;
        dwell_expire = auto_rotate & tick & (dwell_cnt == DWELL_W'(DWELL_MS - 1));
        mode_step    = (display_mode == MODE_W'(NUM_MODES - 1)) ? '0 : display_mode + 1'b1;

        mode_next = display_mode;
        if (uart_sel) begin
            mode_next = MODE_W'(cmd.sel_mode);
        end else if (mode_edge || dwell_expire) begin
            mode_next = mode_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_mode <= MODE_W'(INIT_MODE);
            mode_changed <= 1'b0;
            auto_rotate  <= 1'b0;
        end else begin
            display_mode <= mode_next;
            mode_changed <= (mode_next != display_mode);
            auto_rotate  <= auto_rotate ^ auto_toggle;
        end
    end

    // Held at zero while rotation is off, so enabling it always starts a full dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (!auto_rotate || manual_evt || dwell_expire) begin
            dwell_cnt <= '0;
        end else if (tick) begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    always_comb begin
        stretch_next = stretch_cnt;
        if (data_ready) begin
            stretch_next = STRETCH_W'(STRETCH_MS);
        end else if (tick && stretch_cnt != '0) begin
            stretch_next = stretch_cnt - 1'b1;
        end

        silence_next = silence_cnt;
        if (data_ready) begin
            silence_next = '0;
        end else if (tick && silence_cnt != STALE_W'(STALE_MS)) begin
            silence_next = silence_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stretch_cnt <= '0;
            ready_led   <= 1'b0;
            silence_cnt <= '0;
            stale       <= 1'b0;
        end else begin
            stretch_cnt <= stretch_next;
            ready_led   <= (stretch_next != '0);
            silence_cnt <= silence_next;
            stale       <= (silence_next == STALE_W'(STALE_MS));
        end
    end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl with a 1 kHz clock so every cycle is one ms tick.
module tb_display_mode_ctrl;

    localparam int NUM_MODES  = 3;
    localparam int MODE_W     = 2;
    localparam int INIT_MODE  = 2;
    localparam int CLK_HZ     = 1000;
    localparam int DWELL_MS   = 8;
    localparam int STRETCH_MS = 3;
    localparam int STALE_MS   = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              btn_mode = 1'b0;
    logic              btn_auto = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_done = 1'b0;
    logic              data_ready = 1'b0;
    logic [MODE_W-1:0] display_mode;
    logic              auto_rotate;
    logic              mode_changed;
    logic              ready_led;
    logic              stale;

    int checks = 0;
    int failures = 0;

    int exp_mode_q[$];
    int exp_bit_q[$];

    always #5 clk = ~clk;

    display_mode_ctrl #(
        .NUM_MODES  (NUM_MODES),
        .MODE_W     (MODE_W),
        .INIT_MODE  (INIT_MODE),
        .CLK_HZ     (CLK_HZ),
        .DWELL_MS   (DWELL_MS),
        .STRETCH_MS (STRETCH_MS),
        .STALE_MS   (STALE_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode     (btn_mode),
        .btn_auto     (btn_auto),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .data_ready   (data_ready),
        .display_mode (display_mode),
        .auto_rotate  (auto_rotate),
        .mode_changed (mode_changed),
        .ready_led    (ready_led),
        .stale        (stale)
    );

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (display_mode !== MODE_W'(INIT_MODE)) begin
            failures++;
            $display("[TB] FAIL reset_mode: got %0d expected %0d", display_mode, INIT_MODE);
        end
        checks++;
        if (auto_rotate !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_auto: got %b expected 0", auto_rotate);
        end
        checks++;
        if (mode_changed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_changed: got %b expected 0", mode_changed);
        end
        checks++;
        if (ready_led !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_led: got %b expected 0", ready_led);
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stale: got %b expected 0", stale);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_btn_mode();
        int e;
        int changes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            btn_mode = 1'b1;
            exp_mode_q.push_back((INIT_MODE + 1 + i) % NUM_MODES);
            @(negedge clk);
            btn_mode = 1'b0;
            e = exp_mode_q.pop_front();
            checks++;
            if (display_mode !== MODE_W'(e)) begin
                failures++;
                $display("[TB] FAIL btn_step%0d: got %0d expected %0d", i, display_mode, e);
            end
            checks++;
            if (mode_changed !== 1'b1) begin
                failures++;
                $display("[TB] FAIL btn_changed%0d: got %b expected 1", i, mode_changed);
            end
            @(negedge clk);
            checks++;
            if (mode_changed !== 1'b0) begin
                failures++;
                $display("[TB] FAIL btn_pulse_width%0d: got %b expected 0", i, mode_changed);
            end
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        btn_mode = 1'b1;
        exp_mode_q.push_back((INIT_MODE + 4) % NUM_MODES);
        changes = 0;
        repeat (50) begin
            @(negedge clk);
            if (mode_changed === 1'b1) changes++;
        end
        btn_mode = 1'b0;
        e = exp_mode_q.pop_front();
        checks++;
        if (display_mode !== MODE_W'(e)) begin
            failures++;
            $display("[TB] FAIL btn_hold_mode: got %0d expected %0d", display_mode, e);
        end
        checks++;
        if (changes !== 1) begin
            failures++;
            $display("[TB] FAIL btn_hold_pulses: got %0d expected 1", changes);
        end
    endtask

    task automatic test_uart_select();
        int e;
        logic [7:0] bytes [3];
        logic       exp_chg [3];
        bytes   = '{8'h68, 8'h37, 8'h31};
        exp_chg = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exp_mode_q.push_back(1);
            send_byte(bytes[i]);
            e = exp_mode_q.pop_front();
            checks++;
            if (display_mode !== MODE_W'(e)) begin
                failures++;
                $display("[TB] FAIL uart_mode_%h: got %0d expected %0d", bytes[i], display_mode, e);
            end
            checks++;
            if (mode_changed !== exp_chg[i]) begin
                failures++;
                $display("[TB] FAIL uart_changed_%h: got %b expected %b", bytes[i], mode_changed, exp_chg[i]);
            end
        end
    endtask

    task automatic test_auto_rotate();
        int e;
        exp_bit_q.push_back(1);
        send_byte(8'h52);
        e = exp_bit_q.pop_front();
        checks++;
        if (auto_rotate !== e[0]) begin
            failures++;
            $display("[TB] FAIL auto_on: got %b expected %0d", auto_rotate, e);
        end
        for (int k = 1; k <= 16; k++) exp_mode_q.push_back((k < 8) ? 1 : (k < 16) ? 2 : 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = exp_mode_q.pop_front();
            checks++;
            if (display_mode !== MODE_W'(e)) begin
                failures++;
                $display("[TB] FAIL auto_dwell_c%0d: got %0d expected %0d", k, display_mode, e);
            end
        end
        repeat (5) @(negedge clk);
        btn_mode = 1'b1;
        exp_mode_q.push_back(1);
        @(negedge clk);
        btn_mode = 1'b0;
        e = exp_mode_q.pop_front();
        checks++;
        if (display_mode !== MODE_W'(e)) begin
            failures++;
            $display("[TB] FAIL auto_btn_step: got %0d expected %0d", display_mode, e);
        end
        for (int k = 1; k <= 8; k++) exp_mode_q.push_back((k < 8) ? 1 : 2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = exp_mode_q.pop_front();
            checks++;
            if (display_mode !== MODE_W'(e)) begin
                failures++;
                $display("[TB] FAIL auto_restart_c%0d: got %0d expected %0d", k, display_mode, e);
            end
        end
    endtask

    task automatic test_priority();
        int e;
        @(negedge clk);
        btn_auto = 1'b1;
        rx_data  = 8'h72;
        rx_done  = 1'b1;
        exp_bit_q.push_back(0);
        @(negedge clk);
        btn_auto = 1'b0;
        rx_done  = 1'b0;
        e = exp_bit_q.pop_front();
        checks++;
        if (auto_rotate !== e[0]) begin
            failures++;
            $display("[TB] FAIL dual_toggle: got %b expected %0d", auto_rotate, e);
        end
        @(negedge clk);
        btn_auto = 1'b1;
        exp_bit_q.push_back(1);
        @(negedge clk);
        btn_auto = 1'b0;
        e = exp_bit_q.pop_front();
        checks++;
        if (auto_rotate !== e[0]) begin
            failures++;
            $display("[TB] FAIL btn_auto_toggle: got %b expected %0d", auto_rotate, e);
        end
        exp_bit_q.push_back(0);
        send_byte(8'h72);
        e = exp_bit_q.pop_front();
        checks++;
        if (auto_rotate !== e[0]) begin
            failures++;
            $display("[TB] FAIL uart_r_toggle: got %b expected %0d", auto_rotate, e);
        end
        exp_mode_q.push_back(0);
        send_byte(8'h30);
        e = exp_mode_q.pop_front();
        checks++;
        if (display_mode !== MODE_W'(e) || mode_changed !== 1'b1) begin
            failures++;
            $display("[TB] FAIL digit_select: got mode %0d chg %b expected mode %0d chg 1", display_mode, mode_changed, e);
        end
        @(negedge clk);
        rx_data  = 8'h54;
        rx_done  = 1'b1;
        btn_mode = 1'b1;
        exp_mode_q.push_back(0);
        exp_mode_q.push_back(0);
        @(negedge clk);
        rx_done  = 1'b0;
        btn_mode = 1'b0;
        e = exp_mode_q.pop_front();
        checks++;
        if (display_mode !== MODE_W'(e) || mode_changed !== 1'b0) begin
            failures++;
            $display("[TB] FAIL uart_over_btn: got mode %0d chg %b expected mode %0d chg 0", display_mode, mode_changed, e);
        end
        @(negedge clk);
        e = exp_mode_q.pop_front();
        checks++;
        if (display_mode !== MODE_W'(e)) begin
            failures++;
            $display("[TB] FAIL btn_dropped: got %0d expected %0d", display_mode, e);
        end
    endtask

    // -1 entries mark samples inside the allowed one-tick phase window.
    task automatic test_ready_led();
        int e;
        int single_exp [6];
        int double_exp [7];
        single_exp = '{0, 1, 1, -1, -1, 0};
        double_exp = '{1, 1, 1, 1, -1, -1, 0};
        @(negedge clk);
        foreach (single_exp[i]) exp_bit_q.push_back(single_exp[i]);
        for (int s = 0; s < 6; s++) begin
            if (s > 0) @(negedge clk);
            data_ready = (s == 0);
            e = exp_bit_q.pop_front();
            if (e >= 0) begin
                checks++;
                if (ready_led !== e[0]) begin
                    failures++;
                    $display("[TB] FAIL led_single_s%0d: got %b expected %0d", s, ready_led, e);
                end
            end
        end
        @(negedge clk);
        data_ready = 1'b1;
        foreach (double_exp[i]) exp_bit_q.push_back(double_exp[i]);
        for (int s = 1; s <= 7; s++) begin
            @(negedge clk);
            data_ready = (s == 2);
            e = exp_bit_q.pop_front();
            if (e >= 0) begin
                checks++;
                if (ready_led !== e[0]) begin
                    failures++;
                    $display("[TB] FAIL led_restart_s%0d: got %b expected %0d", s, ready_led, e);
                end
            end
        end
    endtask

    task automatic test_stale_and_reset();
        int e;
        @(negedge clk);
        rx_data    = 8'h52;
        rx_done    = 1'b1;
        data_ready = 1'b1;
        @(negedge clk);
        rx_done    = 1'b0;
        data_ready = 1'b0;
        checks++;
        if (auto_rotate !== 1'b1 || ready_led !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_state: got auto %b led %b expected 1 1", auto_rotate, ready_led);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (display_mode !== MODE_W'(INIT_MODE) || auto_rotate !== 1'b0 || mode_changed !== 1'b0 ||
            ready_led !== 1'b0 || stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got mode %0d auto %b chg %b led %b stale %b expected %0d 0 0 0 0",
                     display_mode, auto_rotate, mode_changed, ready_led, stale, INIT_MODE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= STALE_MS; k++) exp_bit_q.push_back((k >= STALE_MS) ? 1 : 0);
        for (int k = 1; k <= STALE_MS; k++) begin
            @(negedge clk);
            e = exp_bit_q.pop_front();
            checks++;
            if (stale !== e[0]) begin
                failures++;
                $display("[TB] FAIL stale_from_reset_c%0d: got %b expected %0d", k, stale, e);
            end
        end
        checks++;
        if (display_mode !== MODE_W'(INIT_MODE)) begin
            failures++;
            $display("[TB] FAIL mode_after_reset: got %0d expected %0d", display_mode, INIT_MODE);
        end
        data_ready = 1'b1;
        for (int k = 0; k <= STALE_MS; k++) exp_bit_q.push_back((k >= STALE_MS) ? 1 : 0);
        for (int k = 0; k <= STALE_MS; k++) begin
            @(negedge clk);
            data_ready = 1'b0;
            e = exp_bit_q.pop_front();
            checks++;
            if (stale !== e[0]) begin
                failures++;
                $display("[TB] FAIL stale_after_data_c%0d: got %b expected %0d", k, stale, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_btn_mode();
        test_uart_select();
        test_auto_rotate();
        test_priority();
        test_ready_led();
        test_stale_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/display_mode_ctrl.md
Name: display_mode_ctrl

Overview:
- Parametrised display-mode and status controller for the DHT11 air-conditioner design; sits between button debouncers, `uart_manager` RX and `display_controller`.
- Generalises the fixed 3-mode selector to NUM_MODES modes with UART-selectable modes and an auto-rotate (alternating display) mode.
- Adds a stretched data-ready LED and a stale-sensor flag.

Parameters:
- NUM_MODES, 3, number of display modes (2..10); mode 0 = temperature, 1 = humidity, 2 = both.
- MODE_W, 2, display_mode width; must satisfy NUM_MODES <= 2**MODE_W.
- INIT_MODE, 2, mode loaded at reset; must be < NUM_MODES.
- CLK_HZ, 100_000_000, clock frequency; must be a multiple of 1000.
- DWELL_MS, 2000, auto-rotate dwell per mode.
- STRETCH_MS, 100, ready_led on-time after each data_ready.
- STALE_MS, 12000, silence on data_ready before stale asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_mode  in  1  debounced level; each rising edge steps the mode
- btn_auto  in  1  debounced level; each rising edge toggles auto-rotate
- rx_data  in  8  UART received byte
- rx_done  in  1  1-cycle strobe; rx_data valid
- data_ready  in  1  1-cycle strobe from dht11_sensor
- display_mode  out  MODE_W  current mode
- auto_rotate  out  1  auto-rotate enabled
- mode_changed  out  1  1-cycle pulse when display_mode changes
- ready_led  out  1  stretched data_ready
- stale  out  1  no data_ready for STALE_MS

Behaviour:
- Reset values (asynchronous, rst_n=0): display_mode=INIT_MODE, auto_rotate=0, mode_changed=0, ready_led=0, stale=0. All counters clear and button edge registers clear.
- Reset mid-operation aborts all counting. Counting restarts from 0 on the first clk after rst_n deasserts.
- ms tick: one-cycle pulse every CLK_HZ/1000 cycles, free-running from reset. All *_MS counters advance only on this tick.
- Button edges: a registered previous level is held per button. An event is current=1 and previous=0. Held buttons do not repeat.
- UART decode (only in a cycle with rx_done=1):
  - 'T'/'t' selects mode 0; 'H'/'h' selects 1; 'A'/'a' selects 2.
  - '0'..'9' selects mode n.
  - 'R'/'r' toggles auto_rotate.
  - A select of n >= NUM_MODES is ignored. Any other byte is ignored.
- Mode update priority, all in the same cycle, outputs registered with 1-cycle latency:
  1. A UART select sets display_mode=n.
  2. Else a btn_mode edge steps the mode: NUM_MODES-1 wraps to 0, otherwise +1.
  3. Else a dwell expiry with auto_rotate=1 steps the mode with the same wrap.
- The losing events in a priority conflict are dropped, not queued.
- Auto-rotate toggle sources are btn_auto edge and UART 'R'. If both occur in one cycle, a single toggle is applied.
- Dwell counter:
  - Counts ms ticks while auto_rotate=1 and expires at DWELL_MS.
  - Cleared when auto_rotate=0, on any manual mode event (UART select or btn_mode edge, even if the mode value is unchanged), on expiry, and when auto_rotate toggles 0->1.
- mode_changed = 1 for exactly the first cycle in which display_mode holds a new value. It is not asserted when a select writes the same value.
- ready_led:
  - Goes to 1 the cycle after data_ready.
  - Stays on for STRETCH_MS ms ticks after the strobe, with a ±1 tick phase error.
  - A data_ready while lit restarts the stretch.
- stale:
  - A silence counter counts ms ticks and saturates at STALE_MS.
  - stale=1 once the count reaches STALE_MS.
  - data_ready clears the count and stale on the next cycle; data_ready takes priority over a simultaneous tick.
  - stale asserts after STALE_MS from reset if no data arrives.

Decomposition:
- Package `display_pkg`:
  - Mode encoding constants: MODE_TEMP=0, MODE_HUMI=1, MODE_BOTH=2.
  - UART command byte constants: 8'h54/74, 8'h48/68, 8'h41/61, 8'h52/72, and 8'h30..8'h39.
  - MS_DIV function (CLK_HZ/1000).
- One sub-module `ms_tick_gen` (parameter CLK_HZ; ports clk, rst_n, tick), shared by the dwell, stretch and stale counters.

Test Plan (bench parameters: CLK_HZ=1000 so 1 tick/cycle, DWELL_MS=8, STRETCH_MS=3, STALE_MS=20, NUM_MODES=3, INIT_MODE=2):
- Reset, then 3 btn_mode rising edges spaced 5 cycles apart -> display_mode 2->0->1->2, with one mode_changed pulse each. Holding btn_mode for 50 cycles -> no further change.
- rx_done with 'h' -> display_mode=1 next cycle. Then '7' -> ignored, no mode_changed. Then '1' -> no mode_changed (same value).
- 'R' -> auto_rotate=1; display_mode advances every 8 cycles (1->2->0). A btn_mode edge at dwell count 5 -> immediate step and the next auto step comes 8 cycles later.
- rx_done 'T' and btn_mode edge in the same cycle -> display_mode=0 and the button is dropped. btn_auto edge plus 'r' in the same cycle -> exactly one toggle.
- data_ready pulse -> ready_led high for 3 cycles (±1). A second pulse 2 cycles later -> ready_led stays high 3 more cycles.
- No data_ready for 20 cycles after reset -> stale=1. A data_ready -> stale=0 next cycle and re-asserts 20 cycles later. Assert rst_n=0 mid-count -> all outputs go to reset values immediately.
